alu_issue_stage: RTL and testbench

- ID/EX issue register for the 5-stage MIPS pipeline.
- Decodes the ID-stage instruction into the 5-bit ALU opcode and operand pair, selecting register values, shift amount or extended immediate.
- Registers the result, together with writeback control, into the EX stage that drives the ALU.
- Supports stall (hold), flush (bubble), and counts illegal opcodes.

---
 rtl/alu_issue_stage.sv | 112 +++++++++++
 tb/tb_alu_issue_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue register that decodes MIPS ALU instructions into opcode, operands and writeback control
module alu_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             stall,
    input  logic             flush,
    output logic             in_ready,
    output logic             ex_valid,
    output logic [4:0]       ex_alu_op,
    output logic [31:0]      ex_alu_a,
    output logic [31:0]      ex_alu_b,
    output logic             ex_wr_en,
    output logic [4:0]       ex_wr_reg,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] ill_count
);
    localparam logic [4:0] NOP = 5'h00, ADD = 5'h01, SUB = 5'h02, AND = 5'h03, OR = 5'h04,
                           XOR = 5'h05, NOR = 5'h06, SLL = 5'h07, SRL = 5'h08, SRA = 5'h09,
                           LUI = 5'h0A, SLT = 5'h0B, SLTU = 5'h0C;
    logic [5:0]  opc, fn;
    logic [31:0] se, ze, d_a, d_b;
    logic [4:0]  d_op, d_dest;
    logic        d_legal, unused_rs;
    assign opc       = instr[31:26];
    assign fn        = instr[5:0];
    assign se        = {{16{instr[15]}}, instr[15:0]};
    assign ze        = {16'h0, instr[15:0]};
    assign in_ready  = !stall;
    assign unused_rs = ^instr[25:21];
    always_comb begin
        d_legal = 1'b1;
        d_op    = NOP;
        d_a     = rs_val;
        d_b     = rt_val;
        d_dest  = instr[15:11];
        if (opc == 6'h00) begin
            case (fn)
                6'h20, 6'h21: d_op = ADD;
                6'h22, 6'h23: d_op = SUB;
                6'h24: d_op = AND;
                6'h25: d_op = OR;
                6'h26: d_op = XOR;
                6'h27: d_op = NOR;
                6'h2A: d_op = SLT;
                6'h2B: d_op = SLTU;
                6'h00: begin d_op = SLL; d_a = {27'b0, instr[10:6]}; end
                6'h02: begin d_op = SRL; d_a = {27'b0, instr[10:6]}; end
                6'h03: begin d_op = SRA; d_a = {27'b0, instr[10:6]}; end
                6'h04: d_op = SLL;
                6'h06: d_op = SRL;
                6'h07: d_op = SRA;
                default: d_legal = 1'b0;
            endcase
        end else begin
            d_dest = instr[20:16];
            d_b    = se;
            case (opc)
                6'h08, 6'h09: d_op = ADD;
                6'h0A: d_op = SLT;
                6'h0B: d_op = SLTU;
                6'h0C: begin d_op = AND; d_b = ze; end
                6'h0D: begin d_op = OR; d_b = ze; end
                6'h0E: begin d_op = XOR; d_b = ze; end
                6'h0F: begin d_op = LUI; d_a = 32'h0; d_b = ze; end
                default: d_legal = 1'b0;
            endcase
        end
        // Illegal words issue as an inert NOP flagged for the exception path
        if (!d_legal) begin
            d_op   = NOP;
            d_a    = 32'h0;
            d_b    = 32'h0;
            d_dest = 5'h0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_alu_op  <= NOP;
            ex_alu_a   <= 32'h0;
            ex_alu_b   <= 32'h0;
            ex_wr_en   <= 1'b0;
            ex_wr_reg  <= 5'h0;
            ex_illegal <= 1'b0;
            ill_count  <= '0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_alu_op  <= NOP;
            ex_alu_a   <= 32'h0;
            ex_alu_b   <= 32'h0;
            ex_wr_en   <= 1'b0;
            ex_wr_reg  <= 5'h0;
            ex_illegal <= 1'b0;
        end else if (!stall) begin
            ex_valid   <= in_valid;
            ex_alu_op  <= in_valid ? d_op : NOP;
            ex_alu_a   <= in_valid ? d_a : 32'h0;
            ex_alu_b   <= in_valid ? d_b : 32'h0;
            ex_wr_en   <= in_valid && d_legal && d_dest != 5'h0;
            ex_wr_reg  <= in_valid ? d_dest : 5'h0;
            ex_illegal <= in_valid && !d_legal;
            if (in_valid && !d_legal && !(&ill_count))
                ill_count <= ill_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed checks of alu_issue_stage against a table-driven reference model
module tb_alu_issue_stage;
    typedef struct packed {
        logic        v;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        we;
        logic [4:0]  wr;
        logic        il;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] instr = 32'h0, rs_val = 32'h0, rt_val = 32'h0;
    logic        in_ready, ex_valid, ex_wr_en, ex_illegal;
    logic [4:0]  ex_alu_op, ex_wr_reg;
    logic [31:0] ex_alu_a, ex_alu_b;
    logic [15:0] ill_count;
    logic        in_ready2, ex_valid2, ex_wr_en2, ex_illegal2;
    logic [4:0]  ex_alu_op2, ex_wr_reg2;
    logic [31:0] ex_alu_a2, ex_alu_b2;
    logic [1:0]  ill_count2;

    int n_chk = 0, n_fail = 0;
    ex_t e = '0;
    int  c16 = 0, c2 = 0;
    int  rop[64], iop[64];
    bit  izext[64];

    always #5 clk = ~clk;

    alu_issue_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .stall(stall), .flush(flush), .in_ready(in_ready), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg),
        .ex_illegal(ex_illegal), .ill_count(ill_count));

    alu_issue_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .stall(stall), .flush(flush), .in_ready(in_ready2), .ex_valid(ex_valid2), .ex_alu_op(ex_alu_op2),
        .ex_alu_a(ex_alu_a2), .ex_alu_b(ex_alu_b2), .ex_wr_en(ex_wr_en2), .ex_wr_reg(ex_wr_reg2),
        .ex_illegal(ex_illegal2), .ill_count(ill_count2));

    function automatic ex_t obs();
        return {ex_valid, ex_alu_op, ex_alu_a, ex_alu_b, ex_wr_en, ex_wr_reg, ex_illegal};
    endfunction

    // Reference decode: table lookup by funct/opcode, -1 marks an illegal word
    function automatic ex_t ref_decode(logic [31:0] w, logic [31:0] rs, logic [31:0] rt);
        ex_t r = '0;
        int op, dest, f, o;
        f = int'(w[5:0]);
        o = int'(w[31:26]);
        op = (o == 0) ? rop[f] : iop[o];
        if (op < 0) begin
            r.v = 1'b1;
            r.il = 1'b1;
            return r;
        end
        r.v = 1'b1;
        r.op = op[4:0];
        if (o == 0) begin
            dest = int'(w[15:11]);
            r.a = (f == 0 || f == 2 || f == 3) ? 32'(w[10:6]) : rs;
            r.b = rt;
        end else begin
            dest = int'(w[20:16]);
            r.a = (o == 15) ? 32'h0 : rs;
            r.b = izext[o] ? 32'(w[15:0]) : 32'(signed'(w[15:0]));
        end
        r.wr = dest[4:0];
        r.we = dest != 0;
        return r;
    endfunction

    task automatic tick();
        ex_t n = e;
        int n16 = c16, n2 = c2;
        if (rst) begin
            n = '0; n16 = 0; n2 = 0;
        end else if (flush) n = '0;
        else if (!stall) begin
            n = in_valid ? ref_decode(instr, rs_val, rt_val) : '0;
            if (n.il) begin
                n16 = (c16 == 65535) ? c16 : c16 + 1;
                n2 = (c2 == 3) ? c2 : c2 + 1;
            end
        end
        @(posedge clk);
        e = n; c16 = n16; c2 = n2;
        #1;
    endtask

    task automatic issue(logic [31:0] w, logic [31:0] rs, logic [31:0] rt);
        in_valid = 1'b1; instr = w; rs_val = rs; rt_val = rt;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b1; flush = 1'b1; in_valid = 1'b1; instr = 32'hFC000000;
        tick(); tick();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        n_chk++;
        if (obs() !== ex_t'('0) || ill_count !== 16'd0 || ill_count2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: got ex=%h cnt=%0d cnt2=%0d, want all zero", obs(), ill_count, ill_count2);
        end
    endtask

    task automatic test_decode_directed();
        logic [31:0] w[5] = '{32'h2065FFFF, 32'h000620C3, 32'h34078001, 32'h3C021234, 32'h00000000};
        logic [31:0] rs[5] = '{32'h10, 32'h5, 32'h0, 32'h77, 32'h9};
        logic [31:0] rt[5] = '{32'h3, 32'h80000000, 32'h1, 32'h2, 32'h4};
        ex_t want[5] = '{
            {1'b1, 5'h01, 32'h10, 32'hFFFFFFFF, 1'b1, 5'd5, 1'b0},
            {1'b1, 5'h09, 32'h3, 32'h80000000, 1'b1, 5'd4, 1'b0},
            {1'b1, 5'h04, 32'h0, 32'h00008001, 1'b1, 5'd7, 1'b0},
            {1'b1, 5'h0A, 32'h0, 32'h00001234, 1'b1, 5'd2, 1'b0},
            {1'b1, 5'h07, 32'h0, 32'h4, 1'b0, 5'd0, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            issue(w[i], rs[i], rt[i]);
            n_chk++;
            if (obs() !== want[i] || e !== want[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] instr=%h: got %h, want %h (model %h)", i, w[i], obs(), want[i], e);
            end
        end
        in_valid = 1'b0;
        tick();
        n_chk++;
        if (obs() !== ex_t'('0)) begin
            n_fail++;
            $display("FAIL idle_bubble: got %h, want 0", obs());
        end
    endtask

    task automatic test_stall_flush();
        ex_t held;
        issue(32'h0043082A, 32'hFFFFFFFF, 32'h1);
        held = obs();
        n_chk++;
        if (held !== e || held.op !== 5'h0B) begin
            n_fail++;
            $display("FAIL slt_load: got %h, want %h", held, e);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue($urandom, $urandom, $urandom);
            n_chk++;
            if (obs() !== held || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h ready=%b, want %h ready=0", i, obs(), in_ready, held);
            end
        end
        flush = 1'b1;
        issue(32'h2065FFFF, 32'h1, 32'h1);
        n_chk++;
        if (obs() !== ex_t'('0)) begin
            n_fail++;
            $display("FAIL stall_flush_bubble: got %h, want 0", obs());
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_illegal();
        rst = 1'b1; tick(); rst = 1'b0;
        issue(32'hFC000000, 32'h5, 32'h6);
        stall = 1'b1;
        issue(32'hFC000000, 32'h5, 32'h6);
        stall = 1'b0;
        issue(32'hFC000000, 32'h5, 32'h6);
        n_chk++;
        if (obs() !== ex_t'({1'b1, 5'h0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b1}) || ill_count !== 16'd2) begin
            n_fail++;
            $display("FAIL illegal: got ex=%h cnt=%0d, want illegal nop cnt=2", obs(), ill_count);
        end
        flush = 1'b1;
        issue(32'hFC000000, 32'h5, 32'h6);
        flush = 1'b0;
        n_chk++;
        if (ill_count !== 16'd2 || ex_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_flush: got cnt=%0d ill=%b, want cnt=2 ill=0", ill_count, ex_illegal);
        end
    endtask

    task automatic test_saturate();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) issue(32'h0000003F, 32'h0, 32'h0);
        n_chk++;
        if (ill_count2 !== 2'd3 || ill_count !== 16'd5) begin
            n_fail++;
            $display("FAIL saturate: got cnt2=%0d cnt=%0d, want cnt2=3 cnt=5", ill_count2, ill_count);
        end
        stall = 1'b1; flush = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        n_chk++;
        if (obs() !== ex_t'('0) || ill_count !== 16'd0 || ill_count2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_over_stall: got ex=%h cnt=%0d cnt2=%0d, want 0", obs(), ill_count, ill_count2);
        end
        issue(32'h2065FFFF, 32'h10, 32'h0);
        n_chk++;
        if (obs() !== e || ex_alu_op !== 5'h01) begin
            n_fail++;
            $display("FAIL resume: got %h, want %h", obs(), e);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0E, 6'h0F};
        for (int i = 0; i < 500; i++) begin
            logic [31:0] w = $urandom;
            if ($urandom_range(0, 9) != 0) w[31:26] = ops[$urandom_range(0, 9)];
            if (w[31:26] == 6'h00 && $urandom_range(0, 1) == 1) w[5:0] = 6'h20 | 6'($urandom_range(0, 11));
            rst = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            in_valid = ($urandom_range(0, 5) != 0);
            instr = w; rs_val = $urandom; rt_val = $urandom;
            #1;
            n_chk++;
            if (in_ready !== !stall) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b, want %b", i, in_ready, !stall);
            end
            tick();
            n_chk++;
            if (obs() !== e || ill_count !== 16'(c16) || ill_count2 !== 2'(c2)) begin
                n_fail++;
                $display("FAIL rand[%0d] instr=%h: got %h cnt=%0d/%0d, want %h cnt=%0d/%0d",
                         i, w, obs(), ill_count, ill_count2, e, c16, c2);
            end
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rop[i] = -1; iop[i] = -1; izext[i] = 1'b0;
        end
        rop[32] = 1; rop[33] = 1; rop[34] = 2; rop[35] = 2; rop[36] = 3; rop[37] = 4; rop[38] = 5;
        rop[39] = 6; rop[42] = 11; rop[43] = 12; rop[0] = 7; rop[2] = 8; rop[3] = 9;
        rop[4] = 7; rop[6] = 8; rop[7] = 9;
        iop[8] = 1; iop[9] = 1; iop[10] = 11; iop[11] = 12; iop[12] = 3; iop[13] = 4; iop[14] = 5; iop[15] = 10;
        izext[12] = 1'b1; izext[13] = 1'b1; izext[14] = 1'b1; izext[15] = 1'b1;
        test_reset();
        test_decode_directed();
        test_stall_flush();
        test_illegal();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
